polar_frame_scheduler: RTL and testbench
========================================

POLAR_FRAME_SCHEDULER -- requirements
Module: polar_frame_scheduler

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1: synchronous, active-low reset (low on a rising clk edge resets the block).
REQ-003 SHALL have port enb, input, 1: clock enable; when low, all registers hold.
REQ-004 SHALL have port cfgLen, input, 10: frame length K in bits; 0 = frames disabled.
REQ-005 SHALL have port cfgGap, input, 4: minimum idle cycles between frames; 0 treated as 1.
REQ-006 SHALL have port start, input, 1: pulse requesting one frame.
REQ-007 SHALL have port srcData, input, 1: source bit (ufix1).
REQ-008 SHALL have port srcValid, input, 1: source bit valid.
REQ-009 SHALL have port srcReady, output, 1: block accepts srcData this cycle.
REQ-010 SHALL have port dataOut, output, 1: framed bit to framing stage dataIn.
REQ-011 SHALL have port validOut, output, 1: framed valid to framing stage validIn.
REQ-012 SHALL have port busy, output, 1: high whenever state is not IDLE.
REQ-013 SHALL have port frameDone, output, 1: one-cycle pulse with last bit of a frame.
REQ-014 SHALL have port underrun, output, 1: sticky error, source starved mid-frame.

Function
REQ-015 SHALL implement states IDLE, SEND, GAP; all transitions only on cycles with enb=1.
REQ-016 IDLE: on start=1 (or pending=1) with cfgLen!=0, SHALL latch K=cfgLen and G=max(cfgGap,1), clear pending, enter SEND; start with cfgLen=0 SHALL be ignored.
REQ-017 SEND: srcReady SHALL be 1 (combinational from state); each enabled SEND cycle is one frame beat.
REQ-018 Each beat SHALL register dataOut<=srcData if srcValid=1, else dataOut<=0 and set underrun; validOut<=1 on every beat, so validOut is contiguous for exactly K cycles.
REQ-019 Latency: beat at cycle n SHALL appear on dataOut/validOut at cycle n+1.
REQ-020 Beat counter SHALL count 0..K-1; on beat K-1, frameDone SHALL assert in the same cycle validOut carries the last bit, and state SHALL go to GAP.
REQ-021 GAP: validOut=0, dataOut=0, srcReady=0 for exactly G enabled cycles; then SEND if pending=1 and cfgLen!=0 (re-latching K, G), else IDLE.
REQ-022 start during SEND or GAP SHALL set pending (one deep); further starts while pending=1 SHALL be dropped.
REQ-023 Changes to cfgLen/cfgGap during SEND/GAP SHALL not affect the current frame.
REQ-024 K=1 SHALL produce a single-cycle validOut pulse with frameDone, followed by GAP.
REQ-025 enb=0 SHALL freeze state, counters, outputs, pending; start/srcValid sampled only when enb=1.
REQ-026 underrun SHALL remain set until reset.

Reset
REQ-027 reset=0 SHALL force IDLE, counters=0, pending=0, dataOut=0, validOut=0, frameDone=0, underrun=0; busy and srcReady=0 follow.
REQ-028 Reset mid-frame SHALL truncate the frame (validOut low next cycle) with no frameDone.

Structure
REQ-029 Package polar_frame_pkg SHALL hold the state enum and constants LEN_W=10, GAP_W=4.
REQ-030 One sub-module, frame_beat_counter (loadable down-counter with terminal flag), SHALL serve both SEND and GAP counting.

Verification
REQ-031 cfgLen=8, cfgGap=2, start pulse, srcValid=1, data 10110011 -> validOut high 8 cycles from one cycle after first accept, dataOut=10110011, frameDone on 8th, then 2 idle cycles.
REQ-032 start held during SEND with cfgLen=4, cfgGap=3 -> second frame begins exactly 3 cycles after first validOut falls; third start dropped.
REQ-033 cfgLen=6, srcValid=0 on beat 3 -> validOut still 6 contiguous cycles, beat 3 dataOut=0, underrun=1 and stays set.
REQ-034 cfgLen=5, enb low 2 cycles mid-frame -> outputs held, frame still exactly 5 enabled beats.
REQ-035 reset=0 at beat 3 of cfgLen=10 -> next cycle validOut=0, busy=0, no frameDone; cfgLen=0 with start -> stays IDLE.

Source files
------------

// File: rtl/polar_frame_pkg.sv
// Shared types and widths for the polar frame scheduler slice.
package polar_frame_pkg;

  localparam int unsigned LEN_W = 10;
  localparam int unsigned GAP_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  // A programmed gap of zero still yields one idle cycle between frames.
  function automatic logic [GAP_W-1:0] eff_gap(input logic [GAP_W-1:0] gap);
    return (gap == '0) ? {{(GAP_W-1){1'b0}}, 1'b1} : gap;
  endfunction

endpackage

// File: rtl/frame_beat_counter.sv
// Loadable down-counter with a terminal flag; times both frame beats and gap cycles.
module frame_beat_counter #(
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enb,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_value,
  output logic         terminal
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (enb) begin
      if (load) begin
        count <= load_value;
      end else if (dec && (count != '0)) begin
        count <= count - 1'b1;
      end
    end
  end

  assign terminal = (count == '0);

endmodule

// File: rtl/polar_frame_scheduler.sv
// Frames a serial source into K-bit bursts with a programmable idle gap between frames.
module polar_frame_scheduler
  import polar_frame_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             enb,
  input  logic [LEN_W-1:0] cfgLen,
  input  logic [GAP_W-1:0] cfgGap,
  input  logic             start,
  input  logic             srcData,
  input  logic             srcValid,
  output logic             srcReady,
  output logic             dataOut,
  output logic             validOut,
  output logic             busy,
  output logic             frameDone,
  output logic             underrun
);

  state_t           state;
  logic             pending;
  logic [GAP_W-1:0] gap_len;
  logic             cnt_load;
  logic             cnt_dec;
  logic [LEN_W-1:0] cnt_value;
  logic             terminal;
  logic             launch_idle;
  logic             launch_gap;

  assign launch_idle = (cfgLen != '0) && (start || pending);
  assign launch_gap  = (cfgLen != '0) && pending;

  // Counter holds K-1 during SEND and G-1 during GAP; terminal marks the final cycle.
  always_comb begin
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    cnt_value = '0;
    unique case (state)
      IDLE: begin
        if (launch_idle) begin
          cnt_load  = 1'b1;
          cnt_value = cfgLen - 1'b1;
        end
      end
      SEND: begin
        if (terminal) begin
          cnt_load  = 1'b1;
          cnt_value = {{(LEN_W-GAP_W){1'b0}}, gap_len} - 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      GAP: begin
        if (terminal) begin
          if (launch_gap) begin
            cnt_load  = 1'b1;
            cnt_value = cfgLen - 1'b1;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: ;
    endcase
  end

  frame_beat_counter #(
    .W(LEN_W)
  ) u_counter (
    .clk        (clk),
    .reset      (reset),
    .enb        (enb),
    .load       (cnt_load),
    .dec        (cnt_dec),
    .load_value (cnt_value),
    .terminal   (terminal)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      pending   <= 1'b0;
      gap_len   <= '0;
      dataOut   <= 1'b0;
      validOut  <= 1'b0;
      frameDone <= 1'b0;
      underrun  <= 1'b0;
    end else if (enb) begin
      dataOut   <= 1'b0;
      validOut  <= 1'b0;
      frameDone <= 1'b0;
      unique case (state)
        IDLE: begin
          if (launch_idle) begin
            state   <= SEND;
            gap_len <= eff_gap(cfgGap);
            pending <= 1'b0;
          end
        end
        SEND: begin
          validOut <= 1'b1;
          dataOut  <= srcValid & srcData;
          if (!srcValid) underrun <= 1'b1;
          if (start) pending <= 1'b1;
          if (terminal) begin
            frameDone <= 1'b1;
            state     <= GAP;
          end
        end
        GAP: begin
          if (start) pending <= 1'b1;
          if (terminal) begin
            if (launch_gap) begin
              state   <= SEND;
              gap_len <= eff_gap(cfgGap);
              pending <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign srcReady = (state == SEND);
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_polar_frame_scheduler.sv
// Directed vector bench for polar_frame_scheduler.
module tb_polar_frame_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enb = 1'b0;
  logic [9:0] cfgLen = '0;
  logic [3:0] cfgGap = '0;
  logic       start = 1'b0;
  logic       srcData = 1'b0;
  logic       srcValid = 1'b0;
  logic       srcReady, dataOut, validOut, busy, frameDone, underrun;

  int checks = 0;
  int errors = 0;

  // exp packs {srcReady, busy, validOut, dataOut, frameDone, underrun}
  typedef struct {
    logic       rst;
    logic       en;
    logic [9:0] len;
    logic [3:0] gap;
    logic       st;
    logic       sd;
    logic       sv;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[$];

  polar_frame_scheduler dut (
    .clk       (clk),
    .reset     (reset),
    .enb       (enb),
    .cfgLen    (cfgLen),
    .cfgGap    (cfgGap),
    .start     (start),
    .srcData   (srcData),
    .srcValid  (srcValid),
    .srcReady  (srcReady),
    .dataOut   (dataOut),
    .validOut  (validOut),
    .busy      (busy),
    .frameDone (frameDone),
    .underrun  (underrun)
  );

  always #5 clk = ~clk;

  task automatic add(input logic rst, input logic en, input logic [9:0] len,
                     input logic [3:0] gap, input logic st, input logic sd,
                     input logic sv, input logic [5:0] exp);
    vec_t v;
    v.rst = rst; v.en = en; v.len = len; v.gap = gap;
    v.st = st; v.sd = sd; v.sv = sv; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic step(input logic rst, input logic en, input logic [9:0] len,
                      input logic [3:0] gap, input logic st, input logic sd,
                      input logic sv);
    @(negedge clk);
    reset = rst; enb = en; cfgLen = len; cfgGap = gap;
    start = st; srcData = sd; srcValid = sv;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input logic [5:0] act, input logic [5:0] exp,
                       input string name, input int idx);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %b expected %b", name, idx, act, exp);
    end
  endtask

  initial begin
    logic [7:0] bits;
    logic       d;
    logic [5:0] e;

    // reset
    add(0, 1, 8, 2, 0, 0, 0, 6'b000000);

    // K=8, G=2, data 10110011
    bits = 8'b10110011;
    add(1, 1, 8, 2, 1, 0, 0, 6'b110000);
    for (int b = 0; b < 8; b++) begin
      d = bits[7-b];
      e = {(b < 7), 1'b1, 1'b1, d, (b == 7), 1'b0};
      add(1, 1, 8, 2, 0, d, 1, e);
    end
    add(1, 1, 8, 2, 0, 0, 0, 6'b010000);
    add(1, 1, 8, 2, 0, 0, 0, 6'b000000);
    add(1, 1, 8, 2, 0, 0, 0, 6'b000000);

    // K=1 with cfgGap=0 (one gap cycle)
    add(1, 1, 1, 0, 1, 0, 0, 6'b110000);
    add(1, 1, 1, 0, 0, 1, 1, 6'b011110);
    add(1, 1, 1, 0, 0, 0, 0, 6'b000000);

    // K=5, enb low two cycles mid-frame; start while frozen is ignored
    add(1, 1, 5, 1, 1, 0, 0, 6'b110000);
    add(1, 1, 5, 1, 0, 1, 1, 6'b111100);
    add(1, 1, 5, 1, 0, 0, 1, 6'b111000);
    add(1, 0, 5, 1, 1, 1, 0, 6'b111000);
    add(1, 0, 5, 1, 1, 1, 0, 6'b111000);
    add(1, 1, 5, 1, 0, 1, 1, 6'b111100);
    add(1, 1, 5, 1, 0, 1, 1, 6'b111100);
    add(1, 1, 5, 1, 0, 0, 1, 6'b011010);
    add(1, 1, 5, 1, 0, 0, 0, 6'b000000);
    add(1, 1, 5, 1, 0, 0, 0, 6'b000000);

    // K=6, source starved on beat 3
    add(1, 1, 6, 1, 1, 0, 0, 6'b110000);
    for (int b = 0; b < 6; b++) begin
      e = {(b < 5), 1'b1, 1'b1, (b != 3), (b == 5), (b >= 3)};
      add(1, 1, 6, 1, 0, 1, (b != 3), e);
    end
    add(1, 1, 6, 1, 0, 0, 0, 6'b000001);
    add(1, 1, 6, 1, 0, 0, 0, 6'b000001);
    add(1, 1, 0, 1, 1, 0, 0, 6'b000001);
    add(0, 1, 0, 1, 0, 0, 0, 6'b000000);

    // K=10 truncated by reset at beat 3, then start with cfgLen=0
    add(1, 1, 10, 1, 1, 0, 0, 6'b110000);
    add(1, 1, 10, 1, 0, 1, 1, 6'b111100);
    add(1, 1, 10, 1, 0, 1, 1, 6'b111100);
    add(1, 1, 10, 1, 0, 1, 1, 6'b111100);
    add(0, 1, 10, 1, 0, 1, 1, 6'b000000);
    add(1, 1, 10, 1, 0, 0, 0, 6'b000000);
    add(1, 1, 0, 1, 1, 0, 0, 6'b000000);
    add(1, 1, 0, 1, 0, 0, 0, 6'b000000);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].len, vecs[i].gap,
           vecs[i].st, vecs[i].sd, vecs[i].sv);
      check({srcReady, busy, validOut, dataOut, frameDone, underrun},
            vecs[i].exp, "vec", i);
    end

    // K=4, G=3: second start pends, third start dropped, cfgLen wiggle mid-frame
    step(0, 1, 4, 3, 0, 0, 0);
    check({validOut, frameDone, busy, underrun}, 4'b0000, "pend_rst", 0);
    for (int c = 0; c < 20; c++) begin
      logic st;
      logic [9:0] len;
      logic ev, ef, eb;
      st  = (c == 0) || (c == 2) || (c == 3);
      len = (c >= 2 && c <= 4) ? 10'd7 : 10'd4;
      step(1, 1, len, 3, st, 1, 1);
      ev = ((c >= 1) && (c <= 4)) || ((c >= 8) && (c <= 11));
      ef = (c == 4) || (c == 11);
      eb = (c <= 13);
      check({validOut, frameDone, busy, underrun}, {ev, ef, eb, 1'b0}, "pend_seq", c);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
